// File: rtl/sp_ram_sync_be.sv
// sp_ram_sync_be: synchronous single-port RAM with byte enables, read-during-write
// mode select, optional output register and a hardware clear sweep.
module sp_ram_sync_be #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int DEPTH      = 1024,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cs_i,
   input  logic                we_i,
   input  logic [WORD_W/8-1:0] be_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [WORD_W-1:0]   din_i,
   input  logic                clr_i,
   output logic [WORD_W-1:0]   dout_o,
   output logic                dout_valid_o,
   output logic                busy_o
);
   localparam int NB = WORD_W / 8;
   typedef enum logic {IDLE, CLEAR} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              acc, in_rng, wr_en, last;
   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] old_w, new_w, res_d, res_q;
   logic              res_vld_q;
   assign busy_o = state_q == CLEAR;
   assign acc    = cs_i && !busy_o;
   assign in_rng = {1'b0, addr_i} < (ADDR_W+1)'(DEPTH);
   assign wr_en  = acc && we_i && in_rng;
   assign old_w  = in_rng ? mem[addr_i] : '0;
   assign last   = cnt_q == ADDR_W'(DEPTH - 1);
   // Out-of-range accesses always return zero, even in write-first mode.
   assign res_d  = (in_rng && RDW_MODE != 0) ? new_w : old_w;
   always_comb begin
      new_w = old_w;
      for (int i = 0; i < NB; i++)
         if (we_i && be_i[i]) new_w[8*i +: 8] = din_i[8*i +: 8];
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         state_d = last ? IDLE : CLEAR;
         cnt_d   = last ? '0 : cnt_q + 1'b1;
      end else if (clr_i) begin
         state_d = CLEAR;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
         cnt_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_vld_q <= acc;
         if (acc) res_q <= res_d;
      end
   // Array is deliberately outside the reset domain; only the sweep zeroes it.
   always_ff @(posedge clk_i)
      if (busy_o) mem[cnt_q] <= '0;
      else if (wr_en) mem[addr_i] <= new_w;
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [WORD_W-1:0] out_q;
         logic              out_vld_q;
         always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) begin
               out_q     <= '0;
               out_vld_q <= 1'b0;
            end else begin
               out_vld_q <= res_vld_q;
               if (res_vld_q) out_q <= res_q;
            end
         assign dout_o       = out_q;
         assign dout_valid_o = out_vld_q;
      end else begin : g_noreg
         assign dout_o       = res_q;
         assign dout_valid_o = res_vld_q;
      end
   endgenerate
endmodule
